// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one 4x4 int8 A/B operand pair and streams it row by row into the systolic array.
module systolic_feeder #(
    parameter bit CLEAR_EN  = 1'b1,
    parameter int DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] matrixA,
    output logic [31:0] matrixB,
    output logic        feed_valid,
    output logic        arr_reset_n,
    input  logic        arr_valid
);
    localparam int DW = $clog2(DRAIN_MAX + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FINISH} state_t;
    state_t state_q;
    logic [1:0] beat_q, row_sel;
    logic [DW-1:0] drain_q;
    logic [127:0] a_q, a_d, b_q, b_d;
    logic [31:0] row_a, row_b;
    // byte i lives at the top of the vector so a row slice is already lane-packed
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == IDLE && wr_en && !wr_sel) a_d[{~wr_addr, 3'd0} +: 8] = wr_data;
        if (state_q == IDLE && wr_en && wr_sel) b_d[{~wr_addr, 3'd0} +: 8] = wr_data;
    end
    assign row_sel = (state_q == STREAM) ? beat_q + 2'd1 : 2'd0;
    assign row_a = a_d[{~row_sel, 5'd0} +: 32];
    assign row_b = b_d[{~row_sel, 5'd0} +: 32];
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            feed_valid  <= 1'b0;
            arr_reset_n <= 1'b1;
            matrixA     <= '0;
            matrixB     <= '0;
            beat_q      <= '0;
            drain_q     <= '0;
        end else begin
            done        <= 1'b0;
            timeout     <= 1'b0;
            arr_reset_n <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (CLEAR_EN) begin
                        state_q     <= CLEAR;
                        arr_reset_n <= 1'b0;
                    end else begin
                        state_q    <= STREAM;
                        beat_q     <= '0;
                        feed_valid <= 1'b1;
                        matrixA    <= row_a;
                        matrixB    <= row_b;
                    end
                end
                CLEAR: begin
                    state_q    <= STREAM;
                    beat_q     <= '0;
                    feed_valid <= 1'b1;
                    matrixA    <= row_a;
                    matrixB    <= row_b;
                end
                STREAM: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_q    <= DRAIN;
                        feed_valid <= 1'b0;
                        matrixA    <= '0;
                        matrixB    <= '0;
                        drain_q    <= '0;
                    end else begin
                        matrixA <= row_a;
                        matrixB <= row_b;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (arr_valid) begin
                        state_q <= FINISH;
                        done    <= 1'b1;
                    end else if (drain_q == DW'(DRAIN_MAX - 1)) begin
                        state_q <= FINISH;
                        timeout <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random operand runs on CLEAR_EN=1 and CLEAR_EN=0 feeders against a cycle-timeline model.
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic reset, wr_en, wr_sel, start;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic bsy[2], dn[2], tmo[2], fv[2], arn[2], avl[2];
    logic [31:0] ma[2], mb[2];
    logic [7:0] am[16], bm[16];
    int total = 0, bad = 0;

    systolic_feeder #(.CLEAR_EN(1'b1), .DRAIN_MAX(15)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(bsy[0]), .done(dn[0]), .timeout(tmo[0]),
        .matrixA(ma[0]), .matrixB(mb[0]), .feed_valid(fv[0]), .arr_reset_n(arn[0]),
        .arr_valid(avl[0]));
    systolic_feeder #(.CLEAR_EN(1'b0), .DRAIN_MAX(15)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(bsy[1]), .done(dn[1]), .timeout(tmo[1]),
        .matrixA(ma[1]), .matrixB(mb[1]), .feed_valid(fv[1]), .arr_reset_n(arn[1]),
        .arr_valid(avl[1]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] row(input bit sel, input int k);
        return sel ? {bm[4*k], bm[4*k+1], bm[4*k+2], bm[4*k+3]}
                   : {am[4*k], am[4*k+1], am[4*k+2], am[4*k+3]};
    endfunction

    task automatic idle_inputs();
        start = 0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
    endtask

    task automatic wr(input bit sel, input int addr, input logic [7:0] d);
        wr_en = 1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
        if (sel) bm[addr] = d; else am[addr] = d;
        @(negedge clk);
        idle_inputs();
    endtask

    // instance i with start sampled at n=0; run finishes (done/timeout visible) at cycle f
    task automatic chk_inst(input int i, input int n, input int f, input bit to);
        int c = (i == 0) ? 1 : 0;
        int k = n - 1 - c;
        bit fd = (k >= 0 && k < 4);
        string s = $sformatf("u%0d@%0d", i, n);
        check({s, " busy"}, 32'(bsy[i]), 32'(n <= f));
        check({s, " done"}, 32'(dn[i]), 32'(n == f && !to));
        check({s, " timeout"}, 32'(tmo[i]), 32'(n == f && to));
        check({s, " arr_reset_n"}, 32'(arn[i]), 32'(!(c == 1 && n == 1)));
        check({s, " feed_valid"}, 32'(fv[i]), 32'(fd));
        check({s, " matrixA"}, ma[i], fd ? row(0, k) : 32'h0);
        check({s, " matrixB"}, mb[i], fd ? row(1, k) : 32'h0);
    endtask

    // v = drain cycle (1-based) on which the array raises valid; >15 means never
    task automatic run(input int v0, input int v1, input bit ws, input int wa, input logic [7:0] wd, input bit junk);
        int v[2], d[2], f[2], fmin, fmax;
        v[0] = v0; v[1] = v1;
        for (int i = 0; i < 2; i++) begin
            d[i] = (i == 0) ? 6 : 5;
            f[i] = d[i] + ((v[i] <= 15) ? v[i] : 15);
        end
        fmin = (f[0] < f[1]) ? f[0] : f[1];
        fmax = (f[0] > f[1]) ? f[0] : f[1];
        start = 1; avl[0] = 0; avl[1] = 0;
        if (ws) begin
            wr_en = 1; wr_sel = 0; wr_addr = 4'(wa); wr_data = wd; am[wa] = wd;
        end
        @(posedge clk);
        for (int n = 1; n <= fmax + 1; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk_inst(i, n, f[i], v[i] > 15);
            if (junk && n <= fmin) begin
                start = 1; wr_en = 1; wr_sel = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
            end else idle_inputs();
            for (int i = 0; i < 2; i++)
                avl[i] = (n < d[i] || n >= f[i]) ? 1'($urandom) : (n == d[i] + v[i] - 1);
        end
        idle_inputs(); avl[0] = 0; avl[1] = 0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1; idle_inputs(); avl[0] = 0; avl[1] = 0;
        for (int i = 0; i < 16; i++) begin am[i] = 0; bm[i] = 0; end
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst busy%0d", i), 32'(bsy[i]), 0);
            check($sformatf("rst done%0d", i), 32'(dn[i]), 0);
            check($sformatf("rst timeout%0d", i), 32'(tmo[i]), 0);
            check($sformatf("rst fv%0d", i), 32'(fv[i]), 0);
            check($sformatf("rst arn%0d", i), 32'(arn[i]), 1);
            check($sformatf("rst ma%0d", i), ma[i], 0);
            check($sformatf("rst mb%0d", i), mb[i], 0);
        end
        reset = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) wr(0, i, 8'(i + 1));
        for (int i = 0; i < 16; i++) wr(1, i, (i % 5 == 0) ? 8'h01 : 8'h00);
        check("rowA1", row(0, 1), 32'h05060708);
        run(7, 7, 0, 0, 0, 0);
        run(99, 99, 0, 0, 0, 1);
        run(15, 16, 1, 5, 8'h7F, 0);
        for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(0, 6);
            for (int j = 0; j < nw; j++) wr(1'($urandom), $urandom_range(0, 15), 8'($urandom));
            run($urandom_range(1, 20), $urandom_range(1, 20), 1'($urandom),
                $urandom_range(0, 15), 8'($urandom), 1'($urandom));
        end
        start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); reset = 1;
        for (int n = 3; n <= 4; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("midrst busy%0d@%0d", i, n), 32'(bsy[i]), 0);
                check($sformatf("midrst fv%0d@%0d", i, n), 32'(fv[i]), 0);
                check($sformatf("midrst arn%0d@%0d", i, n), 32'(arn[i]), 1);
                check($sformatf("midrst ma%0d@%0d", i, n), ma[i], 0);
            end
        end
        reset = 0;
        for (int n = 5; n < 25; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check($sformatf("postrst pulse%0d@%0d", i, n), {30'd0, dn[i], tmo[i]}, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
